// File: rtl/tick_gen_pkg.sv
// Shared types and constants for the multi-channel tick generator.
package tick_gen_pkg;

  localparam int MAX_CH    = 8;
  localparam int MAX_CNT_W = 32;

  localparam int DEFAULT_DIV0 = 50;
  localparam int DEFAULT_DIVN = 1000;
  localparam bit DEFAULT_CASC = 1'b1;

  typedef struct packed {
    logic [MAX_CNT_W-1:0] div;
    logic                 casc;
    logic                 oneshot;
  } tick_ch_cfg_t;

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen_if.sv
// Control/config bus and tick outputs of tick_gen.
// cfg_we is a one-cycle strobe with no ready: the block accepts every write on the edge it is seen.
interface tick_gen_if #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 16
);
  import tick_gen_pkg::*;

  localparam int SEL_W = sel_w(NUM_CH);

  logic              en;
  logic              sync_clr;
  logic              cfg_we;
  logic [SEL_W-1:0]  cfg_sel;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_casc;
  logic              cfg_oneshot;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] active;

  modport master (
    output en, sync_clr, cfg_we, cfg_sel, cfg_div, cfg_casc, cfg_oneshot,
    input  tick, active
  );

  modport slave (
    input  en, sync_clr, cfg_we, cfg_sel, cfg_div, cfg_casc, cfg_oneshot,
    output tick, active
  );

endinterface

// File: rtl/tick_gen_ch.sv
// One tick channel: divisor counter that advances on clk or on the previous channel's wrap.
// One-shot stopping is compiled in only when TICK_GEN_ONESHOT_EN is defined.
module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 50,
  parameter bit DEF_CASC = 1'b0,
  parameter bit FIRST    = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         prev_wrap,
  input  logic         clr,
  input  logic         load,
  input  tick_ch_cfg_t cfg_in,
  output logic         wrap_out,
  output logic         tick,
  output logic         active
);

  localparam tick_ch_cfg_t RST_CFG = '{div:     MAX_CNT_W'(DEF_DIV),
                                       casc:    (FIRST ? 1'b0 : DEF_CASC),
                                       oneshot: 1'b0};

  tick_ch_cfg_t     cfg_q, cfg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             src;
  logic             at_end;

`ifdef TICK_GEN_ONESHOT_EN
  logic done_q, done_d;
  assign active = (cfg_q.div != '0) && !done_q;
`else
  logic unused_oneshot;
  assign unused_oneshot = cfg_q.oneshot;
  assign active         = (cfg_q.div != '0);
`endif

  assign src    = en && (cfg_q.casc ? prev_wrap : 1'b1);
  assign at_end = (MAX_CNT_W'(cnt_q) == (cfg_q.div - MAX_CNT_W'(1)));
  // A write or clear cancels this cycle's wrap, so children see no event either.
  assign wrap_out = src && active && at_end && !load && !clr;
  assign tick     = tick_q;

  always_comb begin
    cfg_d  = cfg_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
`ifdef TICK_GEN_ONESHOT_EN
    done_d = done_q;
`endif
    if (clr || load) begin
      cnt_d = '0;
`ifdef TICK_GEN_ONESHOT_EN
      done_d = 1'b0;
`endif
      if (load) begin
        cfg_d = cfg_in;
        if (FIRST) cfg_d.casc = 1'b0;
      end
    end else if (wrap_out) begin
      cnt_d  = '0;
      tick_d = 1'b1;
`ifdef TICK_GEN_ONESHOT_EN
      if (cfg_q.oneshot) done_d = 1'b1;
`endif
    end else if (src && active) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q  <= RST_CFG;
      cnt_q  <= '0;
      tick_q <= 1'b0;
`ifdef TICK_GEN_ONESHOT_EN
      done_q <= 1'b0;
`endif
    end else begin
      cfg_q  <= cfg_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
`ifdef TICK_GEN_ONESHOT_EN
      done_q <= done_d;
`endif
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel timebase: NUM_CH cascadable divisor channels emitting 1-cycle tick pulses.
// Define TICK_GEN_ONESHOT_EN to honour cfg_oneshot (stop a channel after its first tick).
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int CNT_W    = 16,
  parameter int DEF_DIV0 = DEFAULT_DIV0,
  parameter int DEF_DIVN = DEFAULT_DIVN,
  parameter bit DEF_CASC = DEFAULT_CASC
) (
  input logic       clk,
  input logic       rst,
  tick_gen_if.slave bus
);

  localparam int SEL_W = sel_w(NUM_CH);

  tick_ch_cfg_t      cfg_wr;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] tick_v;
  logic [NUM_CH-1:0] active_v;
  logic              unused_last_wrap;

  always_comb begin
    cfg_wr         = '0;
    cfg_wr.div     = MAX_CNT_W'(bus.cfg_div);
    cfg_wr.casc    = bus.cfg_casc;
    cfg_wr.oneshot = bus.cfg_oneshot;
  end

  // Out-of-range cfg_sel matches no channel, so such writes are dropped.
  for (genvar i = 0; i < MAX_CH; i++) begin : g_ch
    if (i < NUM_CH) begin : g_on
      logic ch_load;
      logic prev_wrap;

      assign ch_load = bus.cfg_we && (bus.cfg_sel == SEL_W'(i));

      if (i == 0) begin : g_head
        assign prev_wrap = 1'b0;
      end else begin : g_link
        assign prev_wrap = wrap[i-1];
      end

      tick_gen_ch #(
        .CNT_W    (CNT_W),
        .DEF_DIV  ((i == 0) ? DEF_DIV0 : DEF_DIVN),
        .DEF_CASC ((i == 0) ? 1'b0 : DEF_CASC),
        .FIRST    (i == 0)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .en        (bus.en),
        .prev_wrap (prev_wrap),
        .clr       (bus.sync_clr),
        .load      (ch_load),
        .cfg_in    (cfg_wr),
        .wrap_out  (wrap[i]),
        .tick      (tick_v[i]),
        .active    (active_v[i])
      );
    end
  end

  assign unused_last_wrap = wrap[NUM_CH-1];
  assign bus.tick         = tick_v;
  assign bus.active       = active_v;

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: expected tick events {channel, cycle} are queued as stimulus is
// driven and matched against every observed tick pulse.
module tb_tick_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cyc = 32'd0;

  int checks = 0;
  int errors = 0;

  logic [34:0] exp_q[$];

  tick_gen_if #(.NUM_CH(3), .CNT_W(16)) bus ();

  tick_gen #(.NUM_CH(3), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // ---------------- driver / scoreboard ----------------
  function automatic void push(input int ch, input logic [31:0] at);
    logic [2:0] c;
    c = ch[2:0];
    exp_q.push_back({c, at});
  endfunction

  task automatic step();
    logic [2:0]  t;
    logic [34:0] e;
    logic [2:0]  c;
    @(negedge clk);
    t = bus.tick;
    for (int i = 0; i < 3; i++) begin
      if (t[i]) begin
        c = i[2:0];
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tick_unexpected: ch%0d ticked at cyc %0d, expected no tick", i, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e !== {c, cyc}) begin
            errors++;
            $display("FAIL tick_match: got ch%0d at cyc %0d, expected ch%0d at cyc %0d",
                     i, cyc, e[34:32], e[31:0]);
          end
        end
      end
    end
    while (exp_q.size() > 0 && exp_q[0][31:0] <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL tick_missed: no tick by cyc %0d, expected ch%0d at cyc %0d", cyc, e[34:32], e[31:0]);
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input logic we, input logic clr, input logic [1:0] sel,
                       input logic [15:0] div, input logic casc, input logic os,
                       output logic [31:0] at);
    bus.cfg_we      = we;
    bus.sync_clr    = clr;
    bus.cfg_sel     = sel;
    bus.cfg_div     = div;
    bus.cfg_casc    = casc;
    bus.cfg_oneshot = os;
    step();
    at = cyc;
    bus.cfg_we   = 1'b0;
    bus.sync_clr = 1'b0;
  endtask

  task automatic drain(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected ticks pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_active(input string name, input logic [2:0] exp);
    checks++;
    if (bus.active !== exp) begin
      errors++;
      $display("FAIL %s_active: got %b, expected %b", name, bus.active, exp);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst             = 1'b0;
    bus.en          = 1'b0;
    bus.sync_clr    = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_sel     = '0;
    bus.cfg_div     = '0;
    bus.cfg_casc    = 1'b0;
    bus.cfg_oneshot = 1'b0;
    run(3);
    checks++;
    if (bus.tick !== 3'b000) begin
      errors++;
      $display("FAIL reset_tick: got %b, expected 000", bus.tick);
    end
    check_active("reset", 3'b111);
  endtask

  task automatic test_defaults();
    logic [31:0] r;
    bus.en = 1'b1;
    rst    = 1'b1;
    r      = cyc;
    for (int k = 1; k <= 1200; k++) begin
      push(0, r + 32'(50 * k));
      if (k == 1000) push(1, r + 32'd50000);
    end
    run(60000);
    check_active("defaults", 3'b111);
    drain("defaults");
  endtask

  task automatic test_div1_and_disable();
    logic [31:0] w, w2, w3, w4;
    pulse(1'b1, 1'b1, 2'd0, 16'd1, 1'b0, 1'b0, w);
    for (int k = 1; k <= 20; k++) push(0, w + 32'(k));
    run(20);
    pulse(1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, w2);
    check_active("div0", 3'b110);
    run(100);
    // ch1 held its count of 20 ch0 wraps while ch0 was disabled
    pulse(1'b1, 1'b0, 2'd0, 16'd1, 1'b0, 1'b0, w3);
    for (int k = 1; k <= 980; k++) push(0, w3 + 32'(k));
    push(1, w3 + 32'd980);
    run(980);
    pulse(1'b1, 1'b0, 2'd0, 16'd50, 1'b0, 1'b0, w4);
    check_active("div_restore", 3'b111);
    drain("div1");
  endtask

  task automatic test_en_gap();
    logic [31:0] c;
    int gap;
    for (int it = 0; it < 2; it++) begin
      gap = (it == 0) ? 17 : int'($urandom_range(1, 30));
      pulse(1'b0, 1'b1, 2'd0, 16'd0, 1'b0, 1'b0, c);
      run(20);
      bus.en = 1'b0;
      run(gap);
      bus.en = 1'b1;
      push(0, c + 32'(50 + gap));
      push(0, c + 32'(100 + gap));
      run(80);
      drain("en_gap");
    end
  endtask

  task automatic test_bad_sel();
    logic [31:0] c, w;
    pulse(1'b0, 1'b1, 2'd0, 16'd0, 1'b0, 1'b0, c);
    pulse(1'b1, 1'b0, 2'd3, 16'd1, 1'b0, 1'b0, w);
    push(0, c + 32'd50);
    run(49);
    check_active("bad_sel", 3'b111);
    drain("bad_sel");
  endtask

  task automatic test_cfg_with_clr();
    logic [31:0] c, w;
    pulse(1'b1, 1'b1, 2'd1, 16'd3, 1'b1, 1'b0, c);
    push(0, c + 32'd50);
    push(0, c + 32'd100);
    push(0, c + 32'd150);
    push(1, c + 32'd150);
    run(150);
    drain("cfg_clr");
    pulse(1'b1, 1'b0, 2'd1, 16'd1000, 1'b1, 1'b0, w);
  endtask

`ifdef TICK_GEN_ONESHOT_EN
  task automatic test_oneshot();
    logic [31:0] c, d, w;
    pulse(1'b1, 1'b1, 2'd2, 16'd2, 1'b0, 1'b1, c);
    push(2, c + 32'd2);
    run(10);
    check_active("oneshot_stop", 3'b011);
    pulse(1'b0, 1'b1, 2'd0, 16'd0, 1'b0, 1'b0, d);
    push(2, d + 32'd2);
    run(10);
    check_active("oneshot_rearm", 3'b011);
    drain("oneshot");
    pulse(1'b1, 1'b0, 2'd2, 16'd1000, 1'b1, 1'b0, w);
  endtask
`else
  task automatic test_oneshot();
    logic [31:0] c, w;
    pulse(1'b1, 1'b1, 2'd2, 16'd2, 1'b0, 1'b1, c);
    for (int k = 1; k <= 5; k++) push(2, c + 32'(2 * k));
    run(10);
    check_active("oneshot_ignored", 3'b111);
    drain("oneshot_ignored");
    pulse(1'b1, 1'b0, 2'd2, 16'd1000, 1'b1, 1'b0, w);
  endtask
`endif

  task automatic test_reset_mid_count();
    logic [31:0] c, r;
    pulse(1'b1, 1'b1, 2'd0, 16'd1, 1'b0, 1'b0, c);
    for (int k = 1; k <= 5; k++) push(0, c + 32'(k));
    run(5);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.tick !== 3'b000) begin
      errors++;
      $display("FAIL async_reset_tick: got %b, expected 000", bus.tick);
    end
    check_active("async_reset", 3'b111);
    run(2);
    checks++;
    if (bus.tick !== 3'b000) begin
      errors++;
      $display("FAIL held_reset_tick: got %b, expected 000", bus.tick);
    end
    rst = 1'b1;
    r   = cyc;
    push(0, r + 32'd50);
    push(0, r + 32'd100);
    run(100);
    drain("reset_mid");
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_defaults();
    test_div1_and_disable();
    test_en_gap();
    test_bad_sel();
    test_cfg_with_clr();
    test_oneshot();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
